// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared register numbers, bit positions and masks for the
//                coprocessor-0 interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    // CP0 register numbers as seen by mfc0/mtc0
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // Field positions inside SR and Cause
    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;

    // Implemented (writable) bits of SR: IM, EXL, IE
    localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

    // Exception code recorded for an interrupt entry
    localparam logic [4:0] EXC_INT = 5'd0;

endpackage : cp0_pkg
`default_nettype wire

// File: rtl/cp0_intc.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_intc
//  Description : Coprocessor-0 interrupt controller. Holds SR, Cause, EPC and
//                PRId, samples device IRQ lines into Cause.IP and raises a
//                single level interrupt request towards the CPU pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_intc
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h0000_2016,
    parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_sel,
    input  logic [4:0]  wr_sel,
    input  logic        we,
    input  logic [31:0] din,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic        exl_set,
    input  logic        exl_clr,
    input  logic [5:0]  hwint,
    output logic        int_req,
    output logic [31:0] epc,
    output logic [31:0] dout
);

    // Architectural state. SR is kept masked so unimplemented bits stay zero.
    logic [31:0] sr_q,        sr_d;
    logic        cause_bd_q,  cause_bd_d;
    logic [5:0]  cause_ip_q;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q,       epc_d;

    logic [31:0] pc_aligned;
    logic [31:0] cause_word;
    logic        unused_pc_bits;

    assign pc_aligned     = {pc[31:2], 2'b00};
    assign unused_pc_bits = ^pc[1:0];

    // Next-state logic; exception entry/exit wins over a coincident mtc0
    always_comb begin
        sr_d        = sr_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;

        // mtc0 is applied first so EXL forcing below overrides its EXL bit
        if (we) begin
            if (wr_sel == CP0_SR) begin
                sr_d = din & SR_WMASK;
            end
            if (wr_sel == CP0_EPC) begin
                epc_d = {din[31:2], 2'b00};
            end
        end

        if (exl_set) begin
            sr_d[EXL_BIT] = 1'b1;
            cause_bd_d    = bd;
            cause_exc_d   = EXC_INT;
            // A delay-slot victim restarts at its branch, one word earlier
            epc_d         = bd ? (pc_aligned - 32'd4) : pc_aligned;
        end else if (exl_clr) begin
            sr_d[EXL_BIT] = 1'b0;
        end
    end

    // State registers with synchronous reset; IP re-samples hwint every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q        <= SR_RESET & SR_WMASK;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            sr_q        <= sr_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= hwint;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    // Assemble Cause with unimplemented bits reading as zero
    always_comb begin
        cause_word                 = 32'd0;
        cause_word[BD_BIT]         = cause_bd_q;
        cause_word[IM_HI:IM_LO]    = cause_ip_q;
        cause_word[EXC_HI:EXC_LO]  = cause_exc_q;
    end

    // Level interrupt request: any pending-and-enabled line while not in EXL
    assign int_req = (|(cause_ip_q & sr_q[IM_HI:IM_LO])) & sr_q[IE_BIT] & ~sr_q[EXL_BIT];

    assign epc = epc_q;

    // mfc0 read mux; returns current register contents (no write bypass)
    always_comb begin
        dout = 32'd0;
        case (rd_sel)
            CP0_SR:    dout = sr_q;
            CP0_CAUSE: dout = cause_word;
            CP0_EPC:   dout = epc_q;
            CP0_PRID:  dout = PRID_VAL;
            default:   dout = 32'd0;
        endcase
    end

endmodule : cp0_intc
`default_nettype wire

// File: tb/tb_cp0_intc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_intc
//  Description : Self-checking bench for cp0_intc. Expected results are queued
//                as stimulus is driven and compared after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_intc;

    localparam int K_INT  = 0;
    localparam int K_EPC  = 1;
    localparam int K_READ = 2;

    typedef struct {
        string       tag;
        int          kind;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [4:0]  rd_sel;
    logic [4:0]  wr_sel;
    logic        we;
    logic [31:0] din;
    logic [31:0] pc;
    logic        bd;
    logic        exl_set;
    logic        exl_clr;
    logic [5:0]  hwint;
    logic        int_req;
    logic [31:0] epc;
    logic [31:0] dout;

    int   n_compared;
    int   n_mismatched;
    exp_t sb_q[$];

    cp0_intc #(
        .PRID_VAL (32'h0000_2016),
        .SR_RESET (32'h0000_0000)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .rd_sel  (rd_sel),
        .wr_sel  (wr_sel),
        .we      (we),
        .din     (din),
        .pc      (pc),
        .bd      (bd),
        .exl_set (exl_set),
        .exl_clr (exl_clr),
        .hwint   (hwint),
        .int_req (int_req),
        .epc     (epc),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int kind, input logic [4:0] rd, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.rd   = rd;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    // Pop every queued expectation and compare against the live outputs
    task automatic drain();
        exp_t e;
        logic [4:0] saved_rd;
        saved_rd = rd_sel;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_INT:   chk(e.tag, {31'd0, int_req}, e.val);
                K_EPC:   chk(e.tag, epc, e.val);
                default: begin
                    rd_sel = e.rd;
                    #1;
                    chk(e.tag, dout, e.val);
                end
            endcase
        end
        rd_sel = saved_rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic idle_inputs();
        we      = 1'b0;
        wr_sel  = 5'd0;
        din     = 32'd0;
        exl_set = 1'b0;
        exl_clr = 1'b0;
        bd      = 1'b0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    int cnt;
    logic irq1;

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset  = 1'b1;
        rd_sel = 5'd0;
        pc     = 32'd0;
        hwint  = 6'd0;
        idle_inputs();

        // 1. reset for two cycles, then timer0 IRQ with SR=0
        step();
        push("rst_int", K_INT, 5'd0, 32'd0);
        push("rst_epc", K_EPC, 5'd0, 32'd0);
        push("rst_sr",  K_READ, 5'd12, 32'd0);
        push("rst_cause", K_READ, 5'd13, 32'd0);
        step();
        reset = 1'b0;
        hwint = 6'b000001;
        push("t1_int",   K_INT,  5'd0,  32'd0);
        push("t1_cause", K_READ, 5'd13, 32'h0000_0400);
        push("t1_prid",  K_READ, 5'd15, 32'h0000_2016);
        push("t1_unimp", K_READ, 5'd3,  32'd0);
        step();

        // 2. enable timer0 with line low, then raise it and watch latency
        hwint  = 6'b000000;
        we     = 1'b1;
        wr_sel = 5'd12;
        din    = 32'h0000_0401;
        push("t2_sr",  K_READ, 5'd12, 32'h0000_0401);
        push("t2_int0", K_INT, 5'd0, 32'd0);
        step();
        idle_inputs();
        hwint = 6'b000001;
        push("t2_int_pre", K_INT, 5'd0, 32'd0);
        drain();
        push("t2_int_lat1", K_INT, 5'd0, 32'd1);
        step();
        exl_set = 1'b1;
        pc      = 32'h0000_3010;
        bd      = 1'b0;
        push("t2_epc", K_EPC, 5'd0, 32'h0000_3010);
        push("t2_sr_exl", K_READ, 5'd12, 32'h0000_0403);
        push("t2_int_exl", K_INT, 5'd0, 32'd0);
        step();

        // 3. delay-slot victim
        pc = 32'h0000_3024;
        bd = 1'b1;
        push("t3_epc", K_EPC, 5'd0, 32'h0000_3020);
        push("t3_cause_bd", K_READ, 5'd13, 32'h8000_0400);
        step();

        // 4. ERET with IRQ still high
        idle_inputs();
        exl_clr = 1'b1;
        push("t4_sr", K_READ, 5'd12, 32'h0000_0401);
        push("t4_int", K_INT, 5'd0, 32'd1);
        push("t4_epc_keep", K_EPC, 5'd0, 32'h0000_3020);
        step();

        // 5. coincident exl_set and mtc0 EPC: exception wins
        idle_inputs();
        exl_set = 1'b1;
        pc      = 32'h0000_3100;
        we      = 1'b1;
        wr_sel  = 5'd14;
        din     = 32'h0000_4000;
        push("t5_epc_prio", K_EPC, 5'd0, 32'h0000_3100);
        push("t5_cause", K_READ, 5'd13, 32'h0000_0400);
        step();
        idle_inputs();
        we     = 1'b1;
        wr_sel = 5'd14;
        din    = 32'h0000_4003;
        push("t5_epc_align", K_READ, 5'd14, 32'h0000_4000);
        step();
        idle_inputs();
        we     = 1'b1;
        wr_sel = 5'd13;
        din    = 32'hFFFF_FFFF;
        push("t5_cause_ro", K_READ, 5'd13, 32'h0000_0400);
        step();

        // Read-before-write returns old SR; then write all-ones
        idle_inputs();
        we     = 1'b1;
        wr_sel = 5'd12;
        din    = 32'hFFFF_FFFF;
        push("t5_nobypass", K_READ, 5'd12, 32'h0000_0403);
        drain();
        push("t5_sr_mask", K_READ, 5'd12, 32'h0000_FC03);
        push("t5_int_exl", K_INT, 5'd0, 32'd0);
        step();

        // exl_clr with mtc0 SR: written value, EXL forced low; IM = timer1 only
        idle_inputs();
        exl_clr = 1'b1;
        we      = 1'b1;
        wr_sel  = 5'd12;
        din     = 32'h0000_0803;
        push("t5_sr_clr", K_READ, 5'd12, 32'h0000_0801);
        push("t5_int_masked", K_INT, 5'd0, 32'd0);
        step();

        // exl_set with mtc0 SR: written value, EXL forced high
        idle_inputs();
        exl_set = 1'b1;
        pc      = 32'h0000_5000;
        we      = 1'b1;
        wr_sel  = 5'd12;
        din     = 32'h0000_0801;
        push("t5_sr_set", K_READ, 5'd12, 32'h0000_0803);
        step();
        idle_inputs();
        exl_clr = 1'b1;
        push("t5_sr_back", K_READ, 5'd12, 32'h0000_0801);
        step();

        // 6. timer1 in auto-reload mode with preset 5 drives hwint[1]
        idle_inputs();
        cnt = 5;
        for (int i = 0; i < 20; i++) begin
            irq1 = (cnt == 0);
            cnt  = (cnt == 0) ? 5 : cnt - 1;
            hwint = {4'b0000, irq1, 1'b0};
            push($sformatf("t6_int_%0d", i), K_INT, 5'd0, {31'd0, irq1});
            step();
        end
        // Reach the next IRQ pulse, then reset while the line is high
        while (cnt != 0) begin
            cnt--;
            hwint = 6'b000000;
            push("t6_int_low", K_INT, 5'd0, 32'd0);
            step();
        end
        hwint = 6'b000010;
        push("t6_int_pulse", K_INT, 5'd0, 32'd1);
        step();
        reset = 1'b1;
        push("t6_rst_int", K_INT, 5'd0, 32'd0);
        push("t6_rst_sr",  K_READ, 5'd12, 32'd0);
        push("t6_rst_cause", K_READ, 5'd13, 32'd0);
        push("t6_rst_epc", K_EPC, 5'd0, 32'd0);
        step();
        reset = 1'b0;
        hwint = 6'b000000;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_cp0_intc
`default_nettype wire

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Coprocessor-0 style interrupt controller that consumes the IRQ outputs of the memory-mapped timers and other devices (HWInt[7:2]).
- Holds SR, Cause, EPC and PRId, and raises a single interrupt request to the CPU pipeline.
- On exception entry it captures the victim PC into EPC; it releases the exception state on ERET.
- Sits between the device/bridge layer and the CPU's M/W-stage exception logic; the CPU accesses it through mfc0/mtc0.

Parameters:
- PRID_VAL, 32'h0000_2016, constant value returned by PRId (reg 15).
- SR_RESET, 32'h0000_0000, value loaded into SR on reset.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- rd_sel  input  5  mfc0 register number for dout
- wr_sel  input  5  mtc0 register number
- we  input  1  mtc0 write strobe
- din  input  32  mtc0 write data
- pc  input  32  PC of the instruction being interrupted
- bd  input  1  that instruction sits in a branch delay slot
- exl_set  input  1  CPU is taking an exception/interrupt this cycle
- exl_clr  input  1  ERET retiring this cycle
- hwint  input  6  device interrupt lines; hwint[0] = timer0 IRQ, hwint[1] = timer1 IRQ
- int_req  output  1  interrupt request to the CPU
- epc  output  32  current EPC, used as the ERET target
- dout  output  32  mfc0 read data

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): full 32 bits, bits [1:0] always 0.
  - PRId (15): PRID_VAL.
- Reset (synchronous):
  - SR = SR_RESET masked to its implemented bits; Cause = 0; EPC = 0.
  - int_req = 0 in the cycle after reset is sampled.
  - Reset overrides every other input.
- IP sampling: Cause.IP <= hwint every cycle, registered, so latency from a device line to IP is 1 cycle.
- int_req is combinational: |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL. Total device-edge-to-int_req latency is 1 cycle.
- Level semantics: IP follows hwint with no sticky latch; the device must hold its IRQ line until software acknowledges it.
- Exception entry (exl_set=1):
  - SR.EXL <= 1.
  - Cause.BD <= bd; Cause.ExcCode <= 0.
  - EPC <= bd ? {pc[31:2],2'b00} - 4 : {pc[31:2],2'b00}.
- ERET (exl_clr=1 and exl_set=0): SR.EXL <= 0. No other field changes.
- mtc0 (we=1):
  - wr_sel 12: SR <= din masked to the implemented bits.
  - wr_sel 14: EPC <= {din[31:2],2'b00}.
  - wr_sel 13, 15 or any other value: ignored, because Cause and PRId are read-only.
- Priority when events coincide in one cycle:
  - reset > exl_set > exl_clr > we.
  - exl_set and we to EPC together: exl_set's EPC is written.
  - exl_set and we to SR together: the mtc0 value is written, then EXL is forced to 1.
  - exl_clr and we to SR together: the mtc0 value is written, then EXL is forced to 0.
- mfc0 read: dout is combinational from rd_sel. Unimplemented register numbers return 0. A read and a write to the same register in one cycle returns the old value (no bypass).
- epc output always equals the EPC register.

Decomposition:
- Shared package cp0_pkg holds:
  - Register numbers: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - Bit-position constants: IM_HI=15, IM_LO=10, EXL_BIT=1, IE_BIT=0, BD_BIT=31, EXC_HI=6, EXC_LO=2.
  - SR_WMASK = 32'h0000_FC03.
  - EXC_INT = 5'd0.
- Single flat module; a sub-module would add no value.

Test Plan:
1. reset held 2 cycles, then hwint=6'b000001 with SR=0 -> int_req stays 0; mfc0 13 reads 32'h0000_0400; mfc0 15 reads 32'h0000_2016.
2. mtc0 12 <- 32'h0000_0401, then timer0 IRQ rises -> int_req=1 exactly 1 cycle later. Drive exl_set with pc=32'h0000_3010, bd=0 -> EPC=32'h0000_3010, SR.EXL=1, int_req=0 next cycle.
3. exl_set with pc=32'h0000_3024, bd=1 -> EPC=32'h0000_3020, mfc0 13 bit31=1.
4. While EXL=1 and IRQ still high, pulse exl_clr -> EXL=0 and int_req=1 again in the same cycle as the EXL clear.
5. Same cycle: exl_set (pc=32'h0000_3100) and mtc0 14 <- 32'h0000_4000 -> EPC=32'h0000_3100. mtc0 14 <- 32'h0000_4003 alone -> EPC reads 32'h0000_4000. mtc0 13 <- 32'hFFFF_FFFF -> Cause unchanged.
6. Timer in mode 1 with preset 5, IM=timer1 bit only (SR=32'h0000_0801) -> int_req pulses follow the timer1 IRQ shifted by 1 cycle. Assert reset mid-pulse -> int_req=0 and SR=0 next cycle.
